dfp_cmd_sequencer: RTL and testbench

Sequences DFPlayer Mini serial command frames from game-state changes, so the audio module's UART line is driven by one arbitrated controller and not by ad-hoc triggers. It sits beside the game FSM: it watches `game_state` and `choice`, decides which command to issue, builds the 10-byte frame with checksum and serialises it on `uart_txd`. A one-entry pending slot arbitrates between the power-on volume command and game-state events. Inter-frame gaps are enforced.

---
 rtl/dfp_pkg.sv | 38 +++
 rtl/dfp_cmd_sequencer_uart_tx.sv | 57 +++++
 rtl/dfp_cmd_sequencer.sv | 156 +++++++++++++++
 tb/tb_dfp_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dfp_pkg.sv
// Shared constants, state encoding and checksum helper for the DFPlayer
// command sequencer.
package dfp_pkg;

  localparam logic [7:0] FRAME_START    = 8'h7E;
  localparam logic [7:0] FRAME_VER      = 8'hFF;
  localparam logic [7:0] FRAME_LEN      = 8'h06;
  localparam logic [7:0] FRAME_FEEDBACK = 8'h00;
  localparam logic [7:0] FRAME_END      = 8'hEF;

  localparam logic [7:0] CMD_PLAY   = 8'h03;
  localparam logic [7:0] CMD_VOLUME = 8'h06;
  localparam logic [7:0] CMD_RESUME = 8'h0D;
  localparam logic [7:0] CMD_PAUSE  = 8'h0E;
  localparam logic [7:0] CMD_STOP   = 8'h16;

  localparam logic [3:0] GS_BEGINNING = 4'd0;
  localparam logic [3:0] GS_INGAME    = 4'd1;
  localparam logic [3:0] GS_HALT      = 4'd2;
  localparam logic [3:0] GS_ENDING    = 4'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GAP
  } seq_state_t;

  // Two's-complement of the byte sum from version through param low, mod 2^16.
  function automatic logic [15:0] frame_checksum(input logic [7:0] cmd,
                                                 input logic [15:0] param);
    logic [15:0] sum;
    sum = {8'h00, FRAME_VER} + {8'h00, FRAME_LEN} + {8'h00, cmd}
        + {8'h00, FRAME_FEEDBACK} + {8'h00, param[15:8]} + {8'h00, param[7:0]};
    return 16'h0000 - sum;
  endfunction

endpackage

// File: rtl/dfp_cmd_sequencer_uart_tx.sv
// 8N1 byte transmitter, LSB first, idle high. A start accepted in the cycle
// that done pulses chains the next byte with no idle cycle in between.
module uart_tx_byte #(
  parameter int BAUD_DIV = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam int BW = $clog2(BAUD_DIV + 1);

  logic          active;
  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [3:0]    next_bit;
  logic [9:0]    shift_q;
  logic          baud_end;

  assign baud_end = (baud_cnt == BW'(BAUD_DIV - 1));
  assign next_bit = bit_idx + 4'd1;
  // done marks the final cycle of the stop bit.
  assign done     = active && baud_end && (bit_idx == 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '1;
      txd      <= 1'b1;
    end else if (start) begin
      shift_q  <= {1'b1, data, 1'b0};
      txd      <= 1'b0;
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (active) begin
      if (baud_end) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          txd    <= 1'b1;
        end else begin
          bit_idx <= next_bit;
          txd     <= shift_q[next_bit];
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dfp_cmd_sequencer.sv
// Turns game-state transitions into DFPlayer command frames on one UART line,
// with a power-on volume frame, a one-entry pending slot and inter-frame gaps.
module dfp_cmd_sequencer
  import dfp_pkg::*;
#(
  parameter int         BAUD_DIV   = 10416,
  parameter int         GAP_CYCLES = 2_000_000,
  parameter logic [7:0] VOLUME     = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] game_state,
  input  logic [1:0] choice,
  output logic       uart_txd,
  output logic       busy,
  output logic [7:0] frames_sent,
  output logic [7:0] last_cmd
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  seq_state_t    state, next_state;
  logic [3:0]    gs_q;
  logic          init_armed;
  logic          pend_valid;
  logic [7:0]    pend_cmd, pend_param;
  logic          ev_valid;
  logic [7:0]    ev_cmd, ev_param;
  logic [7:0]    frame_q [10];
  logic [3:0]    byte_idx;
  logic [GW-1:0] gap_cnt;
  logic          gap_end;
  logic          tx_start, tx_done;
  logic [7:0]    tx_data;
  logic [7:0]    sel_cmd;
  logic [15:0]   sel_param, sel_ck;

  // Transitions involving an out-of-range state (4..15) never fire.
  always_comb begin
    ev_valid = 1'b0;
    ev_cmd   = 8'h00;
    ev_param = 8'h00;
    if (game_state != gs_q && game_state[3:2] == 2'b00 && gs_q[3:2] == 2'b00) begin
      if (game_state == GS_ENDING || game_state == GS_BEGINNING) begin
        ev_valid = 1'b1;
        ev_cmd   = CMD_STOP;
      end else if (gs_q == GS_BEGINNING && game_state == GS_INGAME) begin
        ev_valid = 1'b1;
        ev_cmd   = CMD_PLAY;
        ev_param = {6'b0, choice} + 8'd1;
      end else if (gs_q == GS_INGAME && game_state == GS_HALT) begin
        ev_valid = 1'b1;
        ev_cmd   = CMD_PAUSE;
      end else if (gs_q == GS_HALT && game_state == GS_INGAME) begin
        ev_valid = 1'b1;
        ev_cmd   = CMD_RESUME;
      end
    end
  end

  assign sel_cmd   = init_armed ? CMD_VOLUME : pend_cmd;
  assign sel_param = init_armed ? {8'h00, VOLUME} : {8'h00, pend_param};
  assign sel_ck    = frame_checksum(sel_cmd, sel_param);
  assign gap_end   = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Byte 0 is a constant, so it is handed to the transmitter during LOAD
  // while the rest of the frame is still being latched.
  always_comb begin
    next_state = state;
    tx_start   = 1'b0;
    tx_data    = FRAME_START;
    case (state)
      S_IDLE: if (init_armed || pend_valid) next_state = S_LOAD;
      S_LOAD: begin
        tx_start   = 1'b1;
        next_state = S_SEND;
      end
      S_SEND: begin
        if (tx_done) begin
          if (byte_idx == 4'd9) begin
            next_state = S_GAP;
          end else begin
            tx_start = 1'b1;
            tx_data  = frame_q[byte_idx + 4'd1];
          end
        end
      end
      S_GAP:   if (gap_end) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gs_q        <= GS_BEGINNING;
      init_armed  <= 1'b1;
      pend_valid  <= 1'b0;
      pend_cmd    <= '0;
      pend_param  <= '0;
      last_cmd    <= '0;
      frames_sent <= '0;
      byte_idx    <= '0;
      gap_cnt     <= '0;
      for (int i = 0; i < 10; i++) frame_q[i] <= '0;
    end else begin
      gs_q <= game_state;
      if (state == S_LOAD) begin
        frame_q[0] <= FRAME_START;
        frame_q[1] <= FRAME_VER;
        frame_q[2] <= FRAME_LEN;
        frame_q[3] <= sel_cmd;
        frame_q[4] <= FRAME_FEEDBACK;
        frame_q[5] <= sel_param[15:8];
        frame_q[6] <= sel_param[7:0];
        frame_q[7] <= sel_ck[15:8];
        frame_q[8] <= sel_ck[7:0];
        frame_q[9] <= FRAME_END;
        last_cmd   <= sel_cmd;
        byte_idx   <= '0;
        if (init_armed) init_armed <= 1'b0;
        else            pend_valid <= 1'b0;
      end
      // A fresh event wins over the slot being consumed in the same cycle.
      if (ev_valid) begin
        pend_valid <= 1'b1;
        pend_cmd   <= ev_cmd;
        pend_param <= ev_param;
      end
      if (state == S_SEND && tx_done && byte_idx != 4'd9) byte_idx <= byte_idx + 4'd1;
      if (state == S_GAP) begin
        if (gap_end) begin
          gap_cnt     <= '0;
          frames_sent <= frames_sent + 8'd1;
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (tx_data),
    .txd   (uart_txd),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_dfp_cmd_sequencer.sv
// Bench for dfp_cmd_sequencer: directed steps plus random bursts, frames
// decoded off the serial line and compared with a transaction-level model.
module tb_dfp_cmd_sequencer;

  localparam int B   = 4;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] game_state = 4'd0;
  logic [1:0] choice = 2'd0;
  logic       uart_txd, busy;
  logic [7:0] frames_sent, last_cmd;

  dfp_cmd_sequencer #(.BAUD_DIV(B), .GAP_CYCLES(GAP), .VOLUME(8'd20)) dut (
    .clk         (clk),
    .reset       (reset),
    .game_state  (game_state),
    .choice      (choice),
    .uart_txd    (uart_txd),
    .busy        (busy),
    .frames_sent (frames_sent),
    .last_cmd    (last_cmd)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Line monitor state
  logic [79:0] got_q[$];
  int          gap_q[$];
  int          mon_nbytes = 0;

  // Reference model state
  logic [79:0] exp_q[$];
  logic [3:0]  m_prev = 4'd0;
  bit          m_in_flight = 0;
  bit          m_pend_valid = 0;
  logic [7:0]  m_pend_cmd, m_pend_par;
  int          m_sent = 0;
  logic [7:0]  m_last = 8'h00;
  logic [79:0] last_frame = '0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] make_frame(input logic [7:0] cmd, input logic [7:0] p);
    logic [15:0] ck;
    ck = 16'h0000 - (16'h00FF + 16'h0006 + {8'h00, cmd} + {8'h00, p});
    return {8'h7E, 8'hFF, 8'h06, cmd, 8'h00, 8'h00, p, ck, 8'hEF};
  endfunction

  task automatic push_exp(input logic [7:0] cmd, input logic [7:0] p);
    exp_q.push_back(make_frame(cmd, p));
    m_sent = (m_sent + 1) % 256;
    m_last = cmd;
  endtask

  // Serial decoder: samples each bit mid-cell, assembles 10-byte frames,
  // then measures how long the line stays high while busy after the frame.
  initial begin
    int          cnt = 0;
    bit          active = 0;
    bit          gap_on = 0;
    int          gap_len = 0;
    logic [9:0]  bits = '0;
    logic [79:0] frame = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0; mon_nbytes = 0; gap_on = 0;
      end else begin
        if (gap_on) begin
          if (busy && uart_txd) gap_len++;
          else begin gap_q.push_back(gap_len); gap_on = 0; end
        end
        if (!active) begin
          if (uart_txd == 1'b0) begin active = 1; cnt = 0; end
        end else cnt++;
        if (active) begin
          if (cnt % B == B / 2) bits[cnt / B] = uart_txd;
          if (cnt == 10 * B - 1) begin
            active = 0;
            frame = {frame[71:0], bits[8:1]};
            mon_nbytes++;
            if (mon_nbytes == 10) begin
              got_q.push_back(frame);
              mon_nbytes = 0;
              gap_on = 1;
              gap_len = 0;
            end
          end
        end
      end
    end
  end

  task automatic drive_gs(input logic [3:0] g, input logic [1:0] c);
    bit ok;
    logic [7:0] cmd, p;
    @(negedge clk);
    game_state = g;
    choice = c;
    ok = 0; cmd = 8'h00; p = 8'h00;
    if (m_prev != g && m_prev <= 4'd3 && g <= 4'd3) begin
      if (g == 4'd3 || g == 4'd0)           begin ok = 1; cmd = 8'h16; end
      else if (m_prev == 4'd0 && g == 4'd1) begin ok = 1; cmd = 8'h03; p = 8'(c) + 8'd1; end
      else if (m_prev == 4'd1 && g == 4'd2) begin ok = 1; cmd = 8'h0E; end
      else if (m_prev == 4'd2 && g == 4'd1) begin ok = 1; cmd = 8'h0D; end
    end
    m_prev = g;
    if (ok) begin
      if (!m_in_flight) begin
        push_exp(cmd, p);
        m_in_flight = 1;
      end else begin
        m_pend_valid = 1; m_pend_cmd = cmd; m_pend_par = p;
      end
    end
  endtask

  task automatic wait_quiet();
    int quiet = 0;
    int t = 0;
    if (m_pend_valid) begin push_exp(m_pend_cmd, m_pend_par); m_pend_valid = 0; end
    while (quiet < 4 && t < 5000) begin
      @(negedge clk);
      t++;
      quiet = busy ? 0 : quiet + 1;
    end
    check("quiet_timeout", 80'(t < 5000), 80'd1);
    check("frame_count", 80'(got_q.size()), 80'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      last_frame = got_q.pop_front();
      check("frame_bytes", last_frame, exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
    while (gap_q.size() > 0) check("gap_len", 80'(gap_q.pop_front()), 80'(GAP));
    check("frames_sent", 80'(frames_sent), 80'(m_sent));
    check("last_cmd", 80'(last_cmd), 80'(m_last));
    m_in_flight = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    push_exp(8'h06, 8'd20);
    m_in_flight = 1;
  endtask

  initial begin
    int t;
    // Reset state
    repeat (4) @(negedge clk);
    check("rst_txd", 80'(uart_txd), 80'd1);
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_frames", 80'(frames_sent), 80'd0);
    check("rst_last_cmd", 80'(last_cmd), 80'd0);

    // Init volume frame starts two cycles after release
    release_reset();
    @(posedge clk); @(negedge clk);
    check("init_load_busy", 80'(busy), 80'd1);
    check("init_load_txd", 80'(uart_txd), 80'd1);
    @(posedge clk); @(negedge clk);
    check("init_start_bit", 80'(uart_txd), 80'd0);
    wait_quiet();
    check("init_frame", last_frame, 80'h7EFF0606000014FEE1EF);

    // Play with choice 0, start-bit latency
    drive_gs(4'd1, 2'd0);
    @(posedge clk); @(negedge clk);
    check("play_e_idle", 80'(busy), 80'd0);
    @(posedge clk); @(negedge clk);
    check("play_load_txd", 80'(uart_txd), 80'd1);
    @(posedge clk); @(negedge clk);
    check("play_start_bit", 80'(uart_txd), 80'd0);
    wait_quiet();
    check("play_frame", last_frame, 80'h7EFF0603000001FEF7EF);

    // Pause then resume
    drive_gs(4'd2, 2'd1);
    wait_quiet();
    check("pause_frame", last_frame, 80'h7EFF060E000000FEEDEF);
    drive_gs(4'd1, 2'd1);
    wait_quiet();
    check("resume_frame", last_frame, 80'h7EFF060D000000FEEEEF);

    // Stop frames and ignored out-of-range states
    drive_gs(4'd3, 2'd0);
    wait_quiet();
    check("stop_frame", last_frame, 80'h7EFF0616000000FEE5EF);
    drive_gs(4'd0, 2'd0);
    wait_quiet();
    drive_gs(4'd7, 2'd0);
    wait_quiet();
    drive_gs(4'd0, 2'd0);
    wait_quiet();

    // Reset in the middle of byte 4 of a play frame
    drive_gs(4'd1, 2'd2);
    t = 0;
    while (mon_nbytes != 4 && t < 3000) begin @(negedge clk); t++; end
    check("byte4_timeout", 80'(t < 3000), 80'd1);
    reset = 1'b1;
    game_state = 4'd0;
    @(negedge clk);
    check("midrst_txd", 80'(uart_txd), 80'd1);
    check("midrst_busy", 80'(busy), 80'd0);
    check("midrst_frames", 80'(frames_sent), 80'd0);
    repeat (2) @(negedge clk);
    got_q.delete(); exp_q.delete(); gap_q.delete();
    m_prev = 4'd0; m_in_flight = 0; m_pend_valid = 0; m_sent = 0; m_last = 8'h00;

    // Play then pause both land during the re-sent init frame
    release_reset();
    repeat (20) @(negedge clk);
    drive_gs(4'd1, 2'd3);
    repeat (30) @(negedge clk);
    drive_gs(4'd2, 2'd0);
    wait_quiet();
    check("overwrite_frames", 80'(frames_sent), 80'd2);
    check("overwrite_frame", last_frame, 80'h7EFF060E000000FEEDEF);

    // Random bursts of state changes
    for (int i = 0; i < 14; i++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        drive_gs(4'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
        repeat ($urandom_range(3, 40)) @(negedge clk);
      end
      wait_quiet();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
